// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-target block.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    DEVACK,
    REGPTR,
    PTRACK,
    WDATA,
    WACK,
    RDATA,
    RACK
  } i2c_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the SCL/SDA pads and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  // [1:0] is the 2-flop synchronizer, [2] is the history flop
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_hi_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign sda        = sda_q[1];
  assign scl_hi_c   = scl_q[1] & scl_q[2];
  assign scl_rise_c = scl_q[1] & ~scl_q[2];
  assign scl_fall_c = ~scl_q[1] & scl_q[2];
  assign start_c    = scl_hi_c & sda_q[2] & ~sda_q[1];
  assign stop_c     = scl_hi_c & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_target.sv
// I2C register target: device address match, register pointer, byte writes
// with write strobe, and streaming reads with pointer auto-increment.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h0A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              scl_oe,
  output logic              wr_valid,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic [BYTE_W-1:0] rd_addr,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(BYTE_W);

  logic              sda_s;
  logic              scl_rise_c;
  logic              scl_fall_c;
  logic              start_c;
  logic              stop_c;

  i2c_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [BYTE_W-1:0] wr_addr_d, wr_data_d, rd_addr_d;
  logic              sda_oe_d, wr_valid_d, busy_d;
  logic              ptr_seen_q, ptr_seen_d;
  logic              mack_q, mack_d;
  logic              bit_rise_c, byte_done_c;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda        (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  assign scl_oe      = 1'b0;
  assign bit_rise_c  = scl_rise_c && (cnt_q < BYTE_BITS);
  assign byte_done_c = scl_fall_c && (cnt_q == BYTE_BITS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      sda_oe     <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      ptr_seen_q <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      sda_oe     <= sda_oe_d;
      wr_valid   <= wr_valid_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      rd_addr    <= rd_addr_d;
      busy       <= busy_d;
      ptr_seen_q <= ptr_seen_d;
      mack_q     <= mack_d;
    end
  end

  // Bus conditions pre-empt any bit activity in the same cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    sda_oe_d   = sda_oe;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    rd_addr_d  = rd_addr;
    busy_d     = busy;
    ptr_seen_d = ptr_seen_q;
    mack_d     = mack_q;

    if (stop_c) begin
      state_d    = IDLE;
      cnt_d      = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      ptr_seen_d = 1'b0;
      mack_d     = 1'b0;
    end else if (start_c) begin
      state_d  = DEVADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      mack_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        DEVADDR, REGPTR, WDATA: begin
          if (bit_rise_c) begin
            shreg_d = {shreg_q[BYTE_W-2:0], sda_s};
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (byte_done_c) begin
            if (state_q == DEVADDR) begin
              if (shreg_q[7:1] == DEV_ADDR) begin
                state_d  = DEVACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                ptr_seen_d = 1'b0;
              end
            end else if (state_q == REGPTR) begin
              state_d    = PTRACK;
              rd_addr_d  = shreg_q;
              ptr_seen_d = 1'b1;
              sda_oe_d   = 1'b1;
            end else begin
              state_d    = WACK;
              wr_valid_d = 1'b1;
              wr_addr_d  = rd_addr;
              wr_data_d  = shreg_q;
              rd_addr_d  = rd_addr + BYTE_W'(1);
              sda_oe_d   = 1'b1;
            end
          end
        end
        DEVACK: begin
          if (scl_fall_c) begin
            cnt_d = '0;
            if (shreg_q[0] == I2C_RW_READ) begin
              state_d  = RDATA;
              shreg_d  = rd_data;
              sda_oe_d = ~rd_data[7];
            end else begin
              state_d  = ptr_seen_q ? WDATA : REGPTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        PTRACK, WACK: begin
          if (scl_fall_c) begin
            state_d  = WDATA;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end
        end
        RDATA: begin
          if (bit_rise_c) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (byte_done_c) begin
            state_d  = RACK;
            sda_oe_d = 1'b0;
          end else if (scl_fall_c && cnt_q != '0) begin
            shreg_d  = {shreg_q[BYTE_W-2:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
          end
        end
        RACK: begin
          // Pointer moves at the ACK sample so rd_data settles before the reload
          if (scl_rise_c) begin
            if (!sda_s) begin
              mack_d    = 1'b1;
              rd_addr_d = rd_addr + BYTE_W'(1);
            end else begin
              state_d    = IDLE;
              busy_d     = 1'b0;
              ptr_seen_d = 1'b0;
            end
          end else if (scl_fall_c && mack_q) begin
            state_d  = RDATA;
            cnt_d    = '0;
            mack_d   = 1'b0;
            shreg_d  = rd_data;
            sda_oe_d = ~rd_data[7];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h0A, the 7-bit target address this block answers to.
REQ-002 SHALL have port clk, input, 1, system clock (50 MHz); every register in the block uses its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port scl_in, input, 1, I2C SCL pad level (asynchronous).
REQ-005 SHALL have port sda_in, input, 1, I2C SDA pad level (asynchronous).
REQ-006 SHALL have port sda_oe, output, 1, 1 = pull SDA low (open-drain).
REQ-007 SHALL have port scl_oe, output, 1, held at constant 0 (no clock stretching).
REQ-008 SHALL have port wr_valid, output, 1, one-cycle strobe when a register write completes.
REQ-009 SHALL have port wr_addr, output, 8, register pointer for the write.
REQ-010 SHALL have port wr_data, output, 8, data byte for the write.
REQ-011 SHALL have port rd_addr, output, 8, current register pointer for reads.
REQ-012 SHALL have port rd_data, input, 8, register contents at rd_addr, combinational from the host logic.
REQ-013 SHALL have port busy, output, 1, high while addressed, from address ACK until STOP, a non-matching START, or a read NACK.

Function
REQ-014 SHALL pass scl_in and sda_in through 2-flop synchronizers plus one history flop; edges, START and STOP are detected on the synchronized values.
REQ-015 SHALL detect START (including repeated START) when SDA falls while SCL is high, and STOP when SDA rises while SCL is high.
REQ-016 SHALL sample SDA only on a synchronized SCL rising edge, and change sda_oe only on the cycle after a synchronized SCL falling edge.
REQ-017 FSM states: IDLE, DEVADDR, DEVACK, REGPTR, PTRACK, WDATA, WACK, RDATA, RACK.
REQ-018 START from any state SHALL go to DEVADDR and clear the bit counter; STOP from any state SHALL go to IDLE and release SDA.
REQ-019 DEVADDR SHALL shift in 8 bits MSB-first; if bits[7:1] == DEV_ADDR it SHALL ACK (sda_oe=1 for one SCL period), otherwise it SHALL go to IDLE without ACK.
REQ-020 After the ACK, R/W=0 SHALL go to REGPTR if no pointer has been received since START, else to WDATA; R/W=1 SHALL go to RDATA.
REQ-021 REGPTR SHALL load the 8-bit pointer into rd_addr, then ACK, then go to WDATA.
REQ-022 WDATA SHALL shift in 8 bits, then pulse wr_valid for exactly one clk with wr_addr=pointer, ACK, and post-increment the pointer.
REQ-023 RDATA SHALL latch rd_data at the SCL falling edge that ends the ACK, drive its bits MSB-first (sda_oe = ~bit), then release SDA for RACK.
REQ-024 In RACK, master ACK (SDA=0) SHALL increment the pointer and return to RDATA; master NACK SHALL go to IDLE with SDA released.
REQ-025 The pointer SHALL wrap 8'hFF -> 8'h00 on increment.
REQ-026 A START or STOP in the middle of a byte SHALL discard that partial byte, with no wr_valid and no pointer change.
REQ-027 START/STOP detection SHALL take priority over a bit sample that falls in the same cycle.
REQ-028 Correct operation SHALL require clk >= 20x SCL frequency (100/400 kHz on a 50 MHz clock).

Reset
REQ-029 On reset=1 at a clk edge: state=IDLE, sda_oe=0, scl_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, bit counter=0, synchronizers=1 (bus idle).
REQ-030 Reset asserted mid-transaction SHALL release SDA on the next clk edge, and the block SHALL ignore the bus until the next START.

Structure
REQ-031 The FSM state enum and the I2C_RW_READ/I2C_RW_WRITE constants SHALL live in the shared package i2c_pkg.
REQ-032 Synchronization and START/STOP/edge detection SHALL be one sub-module, i2c_bus_sync; the FSM and shifter stay in i2c_target.

Verification
REQ-033 Write: START, 0x14, 0x05, 0xA5, 0x3C, STOP -> wr_valid pulses twice, (05,A5) then (06,3C); four ACKs seen; rd_addr=07 after STOP.
REQ-034 Read: pointer set to 0x10, repeated START, 0x15, read 2 bytes (ACK then NACK) with rd_data=addr^8'hFF -> bytes EF, EE; SDA released after NACK; busy=0.
REQ-035 Address mismatch: START, 0x20 -> no ACK, sda_oe stays 0, busy=0, no wr_valid until the next START.
REQ-036 Wrap: pointer 0xFF, write 2 bytes -> wr_addr FF then 00.
REQ-037 Abort: STOP after 4 data bits of WDATA -> no wr_valid, state IDLE; reset asserted during RDATA -> sda_oe=0 on the next cycle.
